// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the burst-master FSM state type.
// Contents:
//   BURST_*  : AxBURST encodings (FIXED/INCR/WRAP)
//   RESP_*   : xRESP encodings (OKAY/EXOKAY/SLVERR/DECERR)
//   state_e  : burst-master sequencing states
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_e;

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI4 bus bundle between the burst master and an AXI slave.
// Parameters: DW data width, AW byte-address width, ID_WD ID width.
// Channels  : AW, W, B, AR, R with the usual AXI4 signal names.
// Modports  : master (drives AW/W/AR payload + VALIDs, BREADY/RREADY),
//             slave  (the mirror image).
interface axi_burst_master_if #(
  parameter int DW    = 32,
  parameter int AW    = 8,
  parameter int ID_WD = 2
) ();

  logic             AWVALID;
  logic             AWREADY;
  logic [ID_WD-1:0] AWID;
  logic [AW-1:0]    AWADDR;
  logic [7:0]       AWLEN;
  logic [2:0]       AWSIZE;
  logic [1:0]       AWBURST;

  logic             WVALID;
  logic             WREADY;
  logic [DW-1:0]    WDATA;
  logic [DW/8-1:0]  WSTRB;
  logic             WLAST;

  logic             BVALID;
  logic             BREADY;
  logic [ID_WD-1:0] BID;
  logic [1:0]       BRESP;

  logic             ARVALID;
  logic             ARREADY;
  logic [ID_WD-1:0] ARID;
  logic [AW-1:0]    ARADDR;
  logic [7:0]       ARLEN;
  logic [2:0]       ARSIZE;
  logic [1:0]       ARBURST;

  logic             RVALID;
  logic             RREADY;
  logic [ID_WD-1:0] RID;
  logic [DW-1:0]    RDATA;
  logic [1:0]       RRESP;
  logic             RLAST;

  modport master (
    output AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
    input  AWREADY,
    output WVALID, WDATA, WSTRB, WLAST,
    input  WREADY,
    input  BVALID, BID, BRESP,
    output BREADY,
    output ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
    input  ARREADY,
    input  RVALID, RID, RDATA, RRESP, RLAST,
    output RREADY
  );

  modport slave (
    input  AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
    output AWREADY,
    input  WVALID, WDATA, WSTRB, WLAST,
    output WREADY,
    output BVALID, BID, BRESP,
    input  BREADY,
    input  ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
    output ARREADY,
    output RVALID, RID, RDATA, RRESP, RLAST,
    input  RREADY
  );

endinterface

// File: rtl/axi_rd_checker.sv
// Combinational compare of one R beat against the expected pattern.
// Inputs : seed_i/len_i of the current command, beat_i (index of the beat
//          on the bus), rd_id_i (ID the read was issued with), and the R
//          payload (rdata_i, rid_i, rresp_i, rlast_i).
// Outputs: mism_inc_o (data differs from seed+beat), err_o (bad RRESP,
//          wrong RID or RLAST in the wrong place), last_o (beat == len).
// The caller qualifies all outputs with the R handshake.
module axi_rd_checker
  import axi_pkg::*;
#(
  parameter int DW    = 32,
  parameter int ID_WD = 2
) (
  input  logic [DW-1:0]    seed_i,
  input  logic [7:0]       len_i,
  input  logic [7:0]       beat_i,
  input  logic [ID_WD-1:0] rd_id_i,
  input  logic [DW-1:0]    rdata_i,
  input  logic [ID_WD-1:0] rid_i,
  input  logic [1:0]       rresp_i,
  input  logic             rlast_i,
  output logic             mism_inc_o,
  output logic             err_o,
  output logic             last_o
);

  logic [DW-1:0] exp_data;

  // Pattern wraps naturally modulo 2^DW.
  assign exp_data   = seed_i + DW'(beat_i);
  assign last_o     = (beat_i == len_i);
  assign mism_inc_o = (rdata_i != exp_data);
  assign err_o      = (rresp_i != RESP_OKAY) || (rid_i != rd_id_i) ||
                      (rlast_i != last_o);

endmodule

// File: rtl/axi_burst_master.sv
// Self-checking AXI4 burst master. Each accepted command writes one INCR
// burst of seed, seed+1, ... starting at an aligned address, then reads the
// same range back and counts data mismatches and protocol errors.
// Ports:
//   M_AXI_ACLK / M_AXI_ARSTN : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready    : command handshake (ready only in IDLE)
//   cmd_addr/cmd_len/cmd_seed: burst start address, beats-1, beat-0 data
//   done                     : one-cycle pulse when a command finishes
//   mism_cnt / proto_err     : result of the last command, held until the
//                              next command is accepted
//   m_axi                    : AXI4 master bus (AW/W/B/AR/R)
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 8,
  parameter int ID_WD = 2
) (
  input  logic          M_AXI_ACLK,
  input  logic          M_AXI_ARSTN,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [7:0]    cmd_len,
  input  logic [DW-1:0] cmd_seed,
  output logic          done,
  output logic [8:0]    mism_cnt,
  output logic          proto_err,
  axi_burst_master_if.master m_axi
);

  localparam int            SZ         = $clog2(DW / 8);
  localparam logic [2:0]    AXSIZE     = 3'(SZ);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'((1 << SZ) - 1);

  state_e           state_q;
  logic [AW-1:0]    addr_q;
  logic [7:0]       len_q;
  logic [DW-1:0]    seed_q;
  logic [7:0]       beat_q;
  logic [ID_WD-1:0] wr_id_q;
  logic [ID_WD-1:0] rd_id_q;
  logic             awvalid_q;
  logic             wvalid_q;
  logic [DW-1:0]    wdata_q;
  logic             wlast_q;
  logic             bready_q;
  logic             arvalid_q;
  logic             rready_q;
  logic             done_q;
  logic [8:0]       mism_q;
  logic             perr_q;

  logic [7:0]       beat_d;
  logic [DW-1:0]    wdata_d;
  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic             rd_mism, rd_err, rd_last;

  assign beat_d  = beat_q + 8'd1;
  assign wdata_d = seed_q + DW'(beat_d);

  assign aw_hs = awvalid_q & m_axi.AWREADY;
  assign w_hs  = wvalid_q  & m_axi.WREADY;
  assign b_hs  = bready_q  & m_axi.BVALID;
  assign ar_hs = arvalid_q & m_axi.ARREADY;
  assign r_hs  = rready_q  & m_axi.RVALID;

  axi_rd_checker #(
    .DW    (DW),
    .ID_WD (ID_WD)
  ) u_rd_chk (
    .seed_i     (seed_q),
    .len_i      (len_q),
    .beat_i     (beat_q),
    .rd_id_i    (rd_id_q),
    .rdata_i    (m_axi.RDATA),
    .rid_i      (m_axi.RID),
    .rresp_i    (m_axi.RRESP),
    .rlast_i    (m_axi.RLAST),
    .mism_inc_o (rd_mism),
    .err_o      (rd_err),
    .last_o     (rd_last)
  );

  // Address/len come straight from the latched command registers; they only
  // change on accept, so they are stable for the whole AW and AR phases.
  assign m_axi.AWVALID = awvalid_q;
  assign m_axi.AWID    = wr_id_q;
  assign m_axi.AWADDR  = addr_q;
  assign m_axi.AWLEN   = len_q;
  assign m_axi.AWSIZE  = AXSIZE;
  assign m_axi.AWBURST = BURST_INCR;

  assign m_axi.WVALID  = wvalid_q;
  assign m_axi.WDATA   = wdata_q;
  assign m_axi.WSTRB   = '1;
  assign m_axi.WLAST   = wlast_q;

  assign m_axi.BREADY  = bready_q;

  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.ARID    = rd_id_q;
  assign m_axi.ARADDR  = addr_q;
  assign m_axi.ARLEN   = len_q;
  assign m_axi.ARSIZE  = AXSIZE;
  assign m_axi.ARBURST = BURST_INCR;

  assign m_axi.RREADY  = rready_q;

  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = done_q;
  assign mism_cnt  = mism_q;
  assign proto_err = perr_q;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARSTN) begin
    if (!M_AXI_ARSTN) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      seed_q    <= '0;
      beat_q    <= '0;
      wr_id_q   <= '0;
      rd_id_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      mism_q    <= '0;
      perr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr & ALIGN_MASK;
            len_q     <= cmd_len;
            seed_q    <= cmd_seed;
            beat_q    <= '0;
            mism_q    <= '0;
            perr_q    <= 1'b0;
            awvalid_q <= 1'b1;
            state_q   <= ST_AW;
          end
        end
        ST_AW: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wdata_q   <= seed_q;
            wlast_q   <= (len_q == 8'd0);
            state_q   <= ST_W;
          end
        end
        ST_W: begin
          if (w_hs) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              beat_q   <= '0;
              bready_q <= 1'b1;
              state_q  <= ST_B;
            end else begin
              beat_q  <= beat_d;
              wdata_q <= wdata_d;
              wlast_q <= (beat_d == len_q);
            end
          end
        end
        ST_B: begin
          if (b_hs) begin
            bready_q  <= 1'b0;
            if ((m_axi.BRESP != RESP_OKAY) || (m_axi.BID != wr_id_q)) perr_q <= 1'b1;
            wr_id_q   <= wr_id_q + ID_WD'(1);
            arvalid_q <= 1'b1;
            state_q   <= ST_AR;
          end
        end
        ST_AR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_R;
          end
        end
        ST_R: begin
          if (r_hs) begin
            mism_q <= mism_q + 9'(rd_mism);
            if (rd_err) perr_q <= 1'b1;
            // Termination follows our own beat count, not RLAST, so a slave
            // with a misplaced RLAST cannot stall or truncate the read.
            if (rd_last) begin
              rready_q <= 1'b0;
              beat_q   <= '0;
              rd_id_q  <= rd_id_q + ID_WD'(1);
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              beat_q <= beat_d;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
`timescale 1ns/1ps
module tb_axi_burst_master;
  import axi_pkg::*;

  localparam int DW = 32, AW = 8, ID_WD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] cmd_seed;
  logic          done;
  logic [8:0]    mism_cnt;
  logic          proto_err;

  axi_burst_master_if #(.DW(DW), .AW(AW), .ID_WD(ID_WD)) m_axi ();

  axi_burst_master #(.DW(DW), .AW(AW), .ID_WD(ID_WD)) dut (
    .M_AXI_ACLK  (clk),
    .M_AXI_ARSTN (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_seed    (cmd_seed),
    .done        (done),
    .mism_cnt    (mism_cnt),
    .proto_err   (proto_err),
    .m_axi       (m_axi)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard queues
  logic [DW:0]   w_exp_q[$];   // {wlast, wdata}
  logic [22:0]   aw_exp_q[$];  // {id, addr, len, size, burst}
  logic [22:0]   ar_exp_q[$];
  logic [9:0]    res_exp_q[$]; // {proto_err, mism_cnt}
  logic [ID_WD-1:0] exp_wid = '0, exp_rid = '0;

  // Slave model knobs and state
  bit   bp = 0, b_slverr = 0;
  int   flip_a = -1, flip_b = -1, early_last = -1;
  logic [DW-1:0] mem [64];
  bit   have_aw = 0, b_pend = 0, r_act = 0, r_hold = 0;
  logic [ID_WD-1:0] s_wid = '0, s_rid = '0;
  logic [AW-1:0] s_waddr = '0, s_raddr = '0;
  logic [7:0]    s_wlen = '0, s_rlen = '0;
  int   wbeat = 0, rbeat = 0, w_cnt = 0, r_cnt = 0, idx;
  bit   aw_stall = 0, w_stall = 0, ar_stall = 0;
  logic [17:0]   aw_pay, ar_pay;
  logic [DW:0]   w_pay, we;

  function automatic logic rnd();
    return bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // Slave: outputs change on the falling edge; the handshakes recorded here
  // are the ones the DUT will see on the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      have_aw = 0; b_pend = 0; r_act = 0; r_hold = 0;
      aw_stall = 0; w_stall = 0; ar_stall = 0;
      m_axi.AWREADY = 0; m_axi.WREADY = 0; m_axi.ARREADY = 0;
      m_axi.BVALID = 0; m_axi.BID = '0; m_axi.BRESP = RESP_OKAY;
      m_axi.RVALID = 0; m_axi.RID = '0; m_axi.RDATA = '0;
      m_axi.RRESP = RESP_OKAY; m_axi.RLAST = 0;
    end else begin
      m_axi.AWREADY = !have_aw && !b_pend && rnd();
      m_axi.WREADY  = have_aw && rnd();
      m_axi.ARREADY = !r_act && rnd();
      if (!b_pend) m_axi.BVALID = 0;
      else if (!m_axi.BVALID) m_axi.BVALID = rnd();
      m_axi.BID   = s_wid;
      m_axi.BRESP = b_slverr ? RESP_SLVERR : RESP_OKAY;
      if (!r_act) m_axi.RVALID = 0;
      else if (!r_hold) begin
        m_axi.RVALID = rnd();
        r_hold = m_axi.RVALID;
      end
      idx = (int'(s_raddr >> 2) + rbeat) % 64;
      m_axi.RDATA = mem[idx] ^ (((rbeat == flip_a) || (rbeat == flip_b)) ? DW'(1) : DW'(0));
      m_axi.RLAST = (rbeat == int'(s_rlen)) || (rbeat == early_last);
      m_axi.RID   = s_rid;
      m_axi.RRESP = RESP_OKAY;

      if (aw_stall) chk("aw_stable", {m_axi.AWVALID, m_axi.AWID, m_axi.AWADDR, m_axi.AWLEN}, {1'b1, aw_pay});
      if (w_stall)  chk("w_stable",  {m_axi.WVALID, m_axi.WLAST, m_axi.WDATA}, {1'b1, w_pay});
      if (ar_stall) chk("ar_stable", {m_axi.ARVALID, m_axi.ARID, m_axi.ARADDR, m_axi.ARLEN}, {1'b1, ar_pay});
      aw_stall = m_axi.AWVALID && !m_axi.AWREADY;
      aw_pay   = {m_axi.AWID, m_axi.AWADDR, m_axi.AWLEN};
      w_stall  = m_axi.WVALID && !m_axi.WREADY;
      w_pay    = {m_axi.WLAST, m_axi.WDATA};
      ar_stall = m_axi.ARVALID && !m_axi.ARREADY;
      ar_pay   = {m_axi.ARID, m_axi.ARADDR, m_axi.ARLEN};

      if (m_axi.AWVALID && m_axi.AWREADY) begin
        have_aw = 1; wbeat = 0;
        s_wid = m_axi.AWID; s_waddr = m_axi.AWADDR; s_wlen = m_axi.AWLEN;
        if (aw_exp_q.size() == 0) chk("aw_unexpected", 1, 0);
        else chk("aw_fields", {m_axi.AWID, m_axi.AWADDR, m_axi.AWLEN, m_axi.AWSIZE, m_axi.AWBURST},
                 aw_exp_q.pop_front());
      end
      if (m_axi.WVALID && m_axi.WREADY) begin
        mem[(int'(s_waddr >> 2) + wbeat) % 64] = m_axi.WDATA;
        wbeat++; w_cnt++;
        if (w_exp_q.size() == 0) chk("w_unexpected", 1, 0);
        else begin
          we = w_exp_q.pop_front();
          chk("w_beat", {m_axi.WLAST, m_axi.WSTRB, m_axi.WDATA}, {we[DW], 4'hF, we[DW-1:0]});
        end
        if (m_axi.WLAST) begin have_aw = 0; b_pend = 1; end
      end
      if (m_axi.BVALID && m_axi.BREADY) b_pend = 0;
      if (m_axi.ARVALID && m_axi.ARREADY) begin
        r_act = 1; r_hold = 0; rbeat = 0;
        s_rid = m_axi.ARID; s_raddr = m_axi.ARADDR; s_rlen = m_axi.ARLEN;
        if (ar_exp_q.size() == 0) chk("ar_unexpected", 1, 0);
        else chk("ar_fields", {m_axi.ARID, m_axi.ARADDR, m_axi.ARLEN, m_axi.ARSIZE, m_axi.ARBURST},
                 ar_exp_q.pop_front());
      end
      if (m_axi.RVALID && m_axi.RREADY) begin
        r_hold = 0; r_cnt++; rbeat++;
        if (rbeat > int'(s_rlen)) r_act = 0;
      end
    end
  end

  task automatic prep(input logic [AW-1:0] addr, input logic [7:0] len, input logic [DW-1:0] seed,
                      input logic [8:0] em, input logic ep);
    logic [AW-1:0] a;
    a = addr & 8'hFC;
    for (int i = 0; i <= int'(len); i++) w_exp_q.push_back({(i == int'(len)), seed + DW'(i)});
    aw_exp_q.push_back({exp_wid, a, len, 3'd2, BURST_INCR});
    ar_exp_q.push_back({exp_rid, a, len, 3'd2, BURST_INCR});
    exp_wid = exp_wid + 1'b1;
    exp_rid = exp_rid + 1'b1;
    res_exp_q.push_back({ep, em});
  endtask

  task automatic run_cmd(input string tag, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [DW-1:0] seed, input logic [8:0] em, input logic ep,
                         input int exp_lat, input bit poke);
    int cyc, r0;
    logic [9:0] er;
    prep(addr, len, seed, em, ep);
    @(negedge clk);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    r0 = r_cnt;
    cmd_valid = 1; cmd_addr = addr; cmd_len = len; cmd_seed = seed;
    @(negedge clk);
    cmd_valid = 0;
    cyc = 1;
    while (!done && cyc < 4000) begin
      cmd_valid = poke && (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 0;
    er = res_exp_q.pop_front();
    if (!done) begin
      chk({tag, "_done_timeout"}, 0, 1);
      return;
    end
    if (exp_lat >= 0) chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_result"}, {proto_err, mism_cnt}, er);
    chk({tag, "_r_beats"}, r_cnt - r0, int'(len) + 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {done, cmd_ready, proto_err, mism_cnt}, {1'b0, 1'b1, er});
    if (poke) begin
      repeat (2) @(negedge clk);
      chk({tag, "_no_extra_aw"}, m_axi.AWVALID, 0);
    end
  endtask

  initial begin
    int cyc, w0;
    cmd_valid = 0; cmd_addr = '0; cmd_len = '0; cmd_seed = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk); #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_ctrl", {m_axi.AWVALID, m_axi.WVALID, m_axi.WLAST, m_axi.BREADY,
                     m_axi.ARVALID, m_axi.RREADY, done, proto_err}, 0);
    chk("rst_result", mism_cnt, 0);
    chk("rst_payload", {m_axi.AWID, m_axi.ARID, m_axi.AWADDR, m_axi.AWLEN, m_axi.WDATA}, 0);

    run_cmd("basic",   8'h00, 8'd3, 32'h10,       9'd0, 1'b0, 12, 0);
    run_cmd("single",  8'h20, 8'd0, 32'hCAFE0000, 9'd0, 1'b0, 6,  0);
    run_cmd("seedwrap",8'h30, 8'd1, 32'hFFFFFFFF, 9'd0, 1'b0, 8,  0);
    run_cmd("unalign", 8'h13, 8'd2, 32'h5A5A0000, 9'd0, 1'b0, 10, 0);
    run_cmd("ignore",  8'h40, 8'd2, 32'h77,       9'd0, 1'b0, 10, 1);

    bp = 1;
    for (int k = 0; k < 4; k++)
      run_cmd("bp", 8'($urandom_range(0, 255)), 8'($urandom_range(1, 15)), $urandom, 9'd0, 1'b0, -1, 0);
    bp = 0;

    flip_a = 2; flip_b = 5;
    run_cmd("corrupt", 8'h80, 8'd7, 32'h1000, 9'd2, 1'b0, 20, 0);
    flip_a = -1; flip_b = -1;

    early_last = 1;
    run_cmd("early_rlast", 8'h00, 8'd3, 32'h200, 9'd0, 1'b1, 12, 0);
    early_last = -1;

    b_slverr = 1;
    run_cmd("slverr", 8'h10, 8'd1, 32'h300, 9'd0, 1'b1, 8, 0);
    b_slverr = 0;

    // Abort a burst with reset while beat 2 is on the W channel
    prep(8'h40, 8'd5, 32'hA0, 9'd0, 1'b0);
    w0 = w_cnt;
    @(negedge clk);
    cmd_valid = 1; cmd_addr = 8'h40; cmd_len = 8'd5; cmd_seed = 32'hA0;
    @(negedge clk);
    cmd_valid = 0;
    cyc = 0;
    while ((w_cnt - w0) < 2 && cyc < 100) begin @(negedge clk); #1; cyc++; end
    if ((w_cnt - w0) < 2) chk("abort_wait_timeout", 0, 1);
    @(negedge clk); #1;
    chk("abort_wbeat2", {m_axi.WVALID, m_axi.WDATA}, {1'b1, 32'hA2});
    #1 rst_n = 0;
    #1;
    chk("abort_ctrl", {m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY, m_axi.ARVALID,
                       m_axi.RREADY, done, proto_err, cmd_ready}, 8'b0000_0001);
    chk("abort_result", mism_cnt, 0);
    w_exp_q.delete(); aw_exp_q.delete(); ar_exp_q.delete(); res_exp_q.delete();
    exp_wid = '0; exp_rid = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk); #1;
    chk("abort_idle", {cmd_ready, m_axi.AWVALID, m_axi.WVALID}, 3'b100);

    // IDs after reset follow 0,1,2,3,0 on both AW and AR
    for (int k = 0; k < 5; k++)
      run_cmd("idwrap", 8'(k * 16), 8'd0, 32'(k + 100), 9'd0, 1'b0, 6, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
